// File: rtl/c1541_sd_mux.sv
// c1541_sd_mux: round-robin arbiter that shares one host SD-block channel
// between DRIVES c1541_sd drive instances and routes the 512-byte buffer.
//
// Ports:
//   clk_sys, reset_n                      clock, synchronous active-low reset
//   drv_lba/drv_rd/drv_wr/drv_buff_din    per-drive request side (packed)
//   drv_ack/drv_buff_wr                   per-drive gated host strobes
//   drv_buff_addr/drv_buff_dout           broadcast host buffer bus
//   sd_lba/sd_rd/sd_wr/sd_sel             request presented to the host
//   sd_ack/sd_buff_addr/sd_buff_dout/
//   sd_buff_wr/sd_buff_din                host buffer channel
module c1541_sd_mux #(
    parameter int DRIVES = 2,
    parameter int SELW   = 2
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [32*DRIVES-1:0]  drv_lba,
    input  logic [DRIVES-1:0]     drv_rd,
    input  logic [DRIVES-1:0]     drv_wr,
    output logic [DRIVES-1:0]     drv_ack,
    input  logic [8*DRIVES-1:0]   drv_buff_din,
    output logic [DRIVES-1:0]     drv_buff_wr,
    output logic [8:0]            drv_buff_addr,
    output logic [7:0]            drv_buff_dout,
    output logic [31:0]           sd_lba,
    output logic                  sd_rd,
    output logic                  sd_wr,
    output logic [SELW-1:0]       sd_sel,
    input  logic                  sd_ack,
    input  logic [8:0]            sd_buff_addr,
    input  logic [7:0]            sd_buff_dout,
    input  logic                  sd_buff_wr,
    output logic [7:0]            sd_buff_din
);

    typedef enum logic [1:0] {
        FLUSH,
        IDLE,
        REQ,
        XFER
    } state_t;

    state_t           state;
    logic [SELW-1:0]  gnt;
    logic [SELW-1:0]  last;

    logic [DRIVES-1:0] pend;
    logic              found;
    logic [SELW-1:0]   pick;
    logic              pick_wr;
    logic [31:0]       pick_lba;
    logic              gnt_pend;
    logic [7:0]        gnt_din;

    assign pend = drv_rd | drv_wr;

    // Rotating search starting just after the last completed grant.
    // Both loops have constant bounds so every select is a constant index.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        pick_wr  = 1'b0;
        pick_lba = '0;
        for (int k = 1; k <= DRIVES; k++) begin
            for (int i = 0; i < DRIVES; i++) begin
                if (!found && pend[i] &&
                    i == (int'(last) + k) % DRIVES) begin
                    found    = 1'b1;
                    pick     = SELW'(i);
                    pick_wr  = drv_wr[i];
                    pick_lba = drv_lba[32*i +: 32];
                end
            end
        end
    end

    always_comb begin
        gnt_pend = 1'b0;
        gnt_din  = '0;
        for (int i = 0; i < DRIVES; i++) begin
            if (gnt == SELW'(i)) begin
                gnt_pend = pend[i];
                gnt_din  = drv_buff_din[8*i +: 8];
            end
        end
    end

    always_comb begin
        drv_ack     = '0;
        drv_buff_wr = '0;
        for (int i = 0; i < DRIVES; i++) begin
            drv_ack[i] = sd_ack && (gnt == SELW'(i)) &&
                         (state == REQ || state == XFER);
            drv_buff_wr[i] = sd_buff_wr && sd_ack &&
                             (gnt == SELW'(i)) && (state == XFER);
        end
    end

    assign sd_buff_din   = (state == XFER) ? gnt_din : 8'd0;
    assign drv_buff_addr = sd_buff_addr;
    assign drv_buff_dout = sd_buff_dout;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state  <= FLUSH;
            gnt    <= '0;
            last   <= SELW'(DRIVES - 1);
            sd_lba <= '0;
            sd_sel <= '0;
            sd_rd  <= 1'b0;
            sd_wr  <= 1'b0;
        end else begin
            unique case (state)
                // Let a transfer interrupted by reset drain first.
                FLUSH: begin
                    if (!sd_ack)
                        state <= IDLE;
                end
                IDLE: begin
                    if (found) begin
                        gnt    <= pick;
                        sd_sel <= pick;
                        sd_lba <= pick_lba;
                        sd_wr  <= pick_wr;
                        sd_rd  <= ~pick_wr;
                        state  <= REQ;
                    end
                end
                // Ack has priority over an abort in the same cycle.
                REQ: begin
                    if (sd_ack) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= XFER;
                    end else if (!gnt_pend) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= IDLE;
                    end
                end
                XFER: begin
                    sd_rd <= 1'b0;
                    sd_wr <= 1'b0;
                    if (!sd_ack) begin
                        last  <= gnt;
                        state <= IDLE;
                    end
                end
                default: state <= FLUSH;
            endcase
        end
    end

endmodule

// File: tb/tb_c1541_sd_mux.sv
// tb_c1541_sd_mux: directed bench for c1541_sd_mux with two drives.
// Stimulus and checks happen on the falling clock edge.
module tb_c1541_sd_mux;

    localparam int DRIVES = 2;
    localparam int SELW   = 2;

    logic                 clk_sys = 1'b0;
    logic                 reset_n;
    logic [32*DRIVES-1:0] drv_lba;
    logic [DRIVES-1:0]    drv_rd;
    logic [DRIVES-1:0]    drv_wr;
    logic [DRIVES-1:0]    drv_ack;
    logic [8*DRIVES-1:0]  drv_buff_din;
    logic [DRIVES-1:0]    drv_buff_wr;
    logic [8:0]           drv_buff_addr;
    logic [7:0]           drv_buff_dout;
    logic [31:0]          sd_lba;
    logic                 sd_rd;
    logic                 sd_wr;
    logic [SELW-1:0]      sd_sel;
    logic                 sd_ack;
    logic [8:0]           sd_buff_addr;
    logic [7:0]           sd_buff_dout;
    logic                 sd_buff_wr;
    logic [7:0]           sd_buff_din;

    int n_chk = 0;
    int n_err = 0;

    c1541_sd_mux #(.DRIVES(DRIVES), .SELW(SELW)) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .drv_lba       (drv_lba),
        .drv_rd        (drv_rd),
        .drv_wr        (drv_wr),
        .drv_ack       (drv_ack),
        .drv_buff_din  (drv_buff_din),
        .drv_buff_wr   (drv_buff_wr),
        .drv_buff_addr (drv_buff_addr),
        .drv_buff_dout (drv_buff_dout),
        .sd_lba        (sd_lba),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .sd_sel        (sd_sel),
        .sd_ack        (sd_ack),
        .sd_buff_addr  (sd_buff_addr),
        .sd_buff_dout  (sd_buff_dout),
        .sd_buff_wr    (sd_buff_wr),
        .sd_buff_din   (sd_buff_din)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    // Host serves the currently granted drive s; w selects a sector write.
    task automatic xfer(input int s, input logic w, input string tag);
        int c0;
        int c1;
        int bad;
        logic [7:0] exp_din;
        c0  = 0;
        c1  = 0;
        bad = 0;
        chk({tag, "_sel"}, 32'(sd_sel), s);
        chk({tag, "_rd"}, 32'(sd_rd), 32'(!w));
        chk({tag, "_wr"}, 32'(sd_wr), 32'(w));
        sd_ack = 1'b1;
        #1;
        chk({tag, "_ack"}, 32'(drv_ack), 32'(1 << s));
        tick();
        drv_rd[s] = 1'b0;
        drv_wr[s] = 1'b0;
        chk({tag, "_clr"}, 32'(sd_rd | sd_wr), 0);
        for (int a = 0; a < 512; a++) begin
            exp_din = a[7:0] ^ 8'h5a;
            sd_buff_addr = a[8:0];
            sd_buff_dout = a[7:0] + 8'd3;
            sd_buff_wr   = !w;
            drv_buff_din[8*s +: 8]       = exp_din;
            drv_buff_din[8*(1-s) +: 8]   = 8'hff;
            #1;
            c0 += int'(drv_buff_wr[0]);
            c1 += int'(drv_buff_wr[1]);
            if (w && sd_buff_din !== exp_din)
                bad++;
            if (drv_buff_addr !== a[8:0] ||
                drv_buff_dout !== a[7:0] + 8'd3)
                bad++;
            tick();
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        chk({tag, "_own"}, (s == 0) ? c0 : c1, w ? 0 : 512);
        chk({tag, "_oth"}, (s == 0) ? c1 : c0, 0);
        chk({tag, "_data"}, bad, 0);
        tick();
        chk({tag, "_ackoff"}, 32'(drv_ack), 0);
        chk({tag, "_gap"}, 32'(sd_rd | sd_wr), 0);
    endtask

    initial begin
        reset_n      = 1'b0;
        drv_lba      = '0;
        drv_rd       = '0;
        drv_wr       = '0;
        drv_buff_din = '0;
        sd_ack       = 1'b0;
        sd_buff_addr = '0;
        sd_buff_dout = '0;
        sd_buff_wr   = 1'b0;
        tick();
        tick();
        chk("rst_rd", 32'(sd_rd), 0);
        chk("rst_wr", 32'(sd_wr), 0);
        chk("rst_lba", sd_lba, 0);
        chk("rst_sel", 32'(sd_sel), 0);
        chk("rst_ack", 32'(drv_ack), 0);
        chk("rst_bwr", 32'(drv_buff_wr), 0);
        chk("rst_din", 32'(sd_buff_din), 0);
        reset_n = 1'b1;
        tick();

        // single read on drive 1
        drv_lba[63:32] = 32'h0000_0123;
        drv_lba[31:0]  = 32'h0000_0777;
        drv_rd[1] = 1'b1;
        tick();
        chk("rd_lba", sd_lba, 32'h123);
        xfer(1, 1'b0, "rd");

        // contention straight after reset
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        drv_rd = 2'b11;
        tick();
        chk("ct_lba", sd_lba, 32'h777);
        xfer(0, 1'b0, "ct0");
        tick();
        xfer(1, 1'b0, "ct1");

        // fairness: both re-request after every ack
        drv_rd = 2'b11;
        for (int k = 0; k < 8; k++) begin
            tick();
            xfer(k % 2, 1'b0, "fair");
            drv_rd[k % 2] = 1'b1;
        end
        drv_rd = '0;

        // write path: read and write together on drive 0
        drv_rd[0] = 1'b1;
        drv_wr[0] = 1'b1;
        tick();
        xfer(0, 1'b1, "wr");

        // abort on drive 1 with drive 0 waiting
        drv_rd[1] = 1'b1;
        tick();
        chk("ab_sel", 32'(sd_sel), 1);
        drv_rd[0] = 1'b1;
        tick();
        tick();
        chk("ab_hold", 32'(sd_rd), 1);
        drv_rd[1] = 1'b0;
        tick();
        chk("ab_drop", 32'(sd_rd), 0);
        tick();
        xfer(0, 1'b0, "ab0");

        // reset in the middle of a transfer
        drv_rd[1] = 1'b1;
        tick();
        chk("mr_sel", 32'(sd_sel), 1);
        sd_ack = 1'b1;
        tick();
        sd_buff_wr = 1'b1;
        #1;
        chk("mr_bwr_pre", 32'(drv_buff_wr), 2);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mr_rd", 32'(sd_rd), 0);
        chk("mr_lba", sd_lba, 0);
        chk("mr_sel0", 32'(sd_sel), 0);
        chk("mr_ack", 32'(drv_ack), 0);
        chk("mr_bwr", 32'(drv_buff_wr), 0);
        chk("mr_din", 32'(sd_buff_din), 0);
        tick();
        tick();
        tick();
        chk("mr_flush_rd", 32'(sd_rd), 0);
        chk("mr_flush_bwr", 32'(drv_buff_wr), 0);
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        tick();
        chk("mr_idle_rd", 32'(sd_rd), 0);
        tick();
        chk("mr_regnt_rd", 32'(sd_rd), 1);
        chk("mr_regnt_sel", 32'(sd_sel), 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
